fetch_stage: RTL and testbench

//  IF stage of the 5-stage WISC-F24 pipeline: PC register, next-PC select, IF/ID pipeline register, HLT handling.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage_pc_reg.sv | 16 +
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants, fetch state encoding and decode helper for the WISC-F24 fetch stage.
// Optional perf counters in fetch_stage are enabled with `FETCH_PERF_CNT_EN.
package fetch_stage_pkg;

    localparam int          DEF_DATA_W     = 16;
    localparam int          DEF_CNT_W      = 16;
    localparam logic [15:0] DEF_RESET_PC   = 16'h0000;
    localparam logic [3:0]  DEF_HLT_OPCODE = 4'hF;
    localparam logic [15:0] NOP_INSTR      = 16'h0000;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } fetch_state_t;

    function automatic logic [3:0] op_of(input logic [15:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/branch controls in, imem port, IF/ID register and halt status out.
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              pc_wen;
    logic              if_id_wen;
    logic              branch_taken;
    logic [DATA_W-1:0] branch_target;
    logic [DATA_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic [DATA_W-1:0] if_id_instr;
    logic [DATA_W-1:0] if_id_pc_plus2;
    logic              if_id_valid;
    logic              fetch_halted;

    modport master (
        input  pc_wen, if_id_wen, branch_taken, branch_target, imem_data,
        output imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, fetch_halted
    );

    modport slave (
        output pc_wen, if_id_wen, branch_taken, branch_target, imem_data,
        input  imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, fetch_halted
    );
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: synchronous active-high reset to RESET_PC, load on wen.
module pc_reg #(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)      q <= RESET_PC;
        else if (wen) q <= d;
    end
endmodule

// File: rtl/fetch_stage.sv
// WISC-F24 IF stage: PC, next-PC select, IF/ID register and HLT sequencing.
// `FETCH_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
//
//  state     | meaning
//  RUN       | normal fetch; stalls, redirects and HLT detection active
//  HALT_PEND | HLT sits in IF/ID, PC frozen until IF/ID advances
//  HALTED    | HLT has left IF/ID, fetch idle until reset
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC   = DATA_W'(DEF_RESET_PC),
    parameter logic [3:0]        HLT_OPCODE = DEF_HLT_OPCODE
`ifdef FETCH_PERF_CNT_EN
    , parameter int              CNT_W      = DEF_CNT_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    fetch_stage_if.master     bus
`ifdef FETCH_PERF_CNT_EN
    , output logic [CNT_W-1:0] stall_cnt
    , output logic [CNT_W-1:0] flush_cnt
`endif
);
    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] pc, pc_d, pc_plus2;
    logic              pc_we;
    logic              fetch_hlt;

    logic              ifid_load;
    logic [DATA_W-1:0] instr_d, pc2_d;
    logic              valid_d;
    logic [DATA_W-1:0] instr_q, pc2_q;
    logic              valid_q;

    assign pc_plus2  = pc + DATA_W'(2);
    assign fetch_hlt = (op_of(bus.imem_data[15:0]) == HLT_OPCODE);

    pc_reg #(
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .wen (pc_we),
        .d   (pc_d),
        .q   (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // A squashed (redirected) or stalled word never starts a halt.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:       if (bus.if_id_wen && !bus.branch_taken && fetch_hlt) state_d = HALT_PEND;
            HALT_PEND: if (bus.if_id_wen) state_d = HALTED;
            HALTED:    state_d = HALTED;
            default:   state_d = RUN;
        endcase
    end

    always_comb begin
        pc_we     = 1'b0;
        pc_d      = pc_plus2;
        ifid_load = 1'b0;
        instr_d   = DATA_W'(NOP_INSTR);
        pc2_d     = '0;
        valid_d   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (!bus.if_id_wen) begin
                    pc_we = bus.pc_wen;
                end else if (bus.branch_taken) begin
                    pc_we     = 1'b1;
                    pc_d      = bus.branch_target;
                    ifid_load = 1'b1;
                end else begin
                    pc_we     = bus.pc_wen && !fetch_hlt;
                    ifid_load = 1'b1;
                    instr_d   = bus.imem_data;
                    pc2_d     = pc_plus2;
                    valid_d   = 1'b1;
                end
            end
            HALT_PEND: ifid_load = bus.if_id_wen;
            default:   ifid_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= DATA_W'(NOP_INSTR);
            pc2_q   <= '0;
            valid_q <= 1'b0;
        end else if (ifid_load) begin
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
        end
    end

    assign bus.imem_addr      = pc;
    assign bus.if_id_instr    = instr_q;
    assign bus.if_id_pc_plus2 = pc2_q;
    assign bus.if_id_valid    = valid_q;
    assign bus.fetch_halted   = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic stall_evt, flush_evt;
    assign stall_evt = (state_q == RUN) && !bus.if_id_wen;
    assign flush_evt = (state_q == RUN) && bus.if_id_wen && bus.branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a behavioural pipeline model.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if #(.DATA_W(16)) bus ();

    logic [15:0] mem [0:255];
    assign bus.imem_data = mem[bus.imem_addr[8:1]];

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
    fetch_stage dut (.clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
    fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // model of architectural fetch state
    logic [15:0] m_pc, m_instr, m_pc2;
    logic        m_valid, m_pc2_chk, m_hlt_in_ifid, m_halted;
    int          m_stall, m_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", 32'(bus.imem_addr), 32'(m_pc));
        chk("if_id_instr", 32'(bus.if_id_instr), 32'(m_instr));
        chk("if_id_valid", 32'(bus.if_id_valid), 32'(m_valid));
        chk("fetch_halted", 32'(bus.fetch_halted), 32'(m_halted));
        if (m_pc2_chk) chk("if_id_pc_plus2", 32'(bus.if_id_pc_plus2), 32'(m_pc2));
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
`endif
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_edge(input logic pw, input logic iw, input logic bt, input logic [15:0] tgt);
        logic [15:0] word;
        word = mem[m_pc[8:1]];
        if (m_halted) begin
        end else if (m_hlt_in_ifid) begin
            if (iw) begin
                m_instr = 16'h0000; m_valid = 1'b0; m_pc2_chk = 1'b0;
                m_hlt_in_ifid = 1'b0; m_halted = 1'b1;
            end
        end else if (!iw) begin
            m_stall = sat_inc(m_stall);
            if (pw) m_pc = m_pc + 16'd2;
        end else if (bt) begin
            m_flush = sat_inc(m_flush);
            m_pc = tgt;
            m_instr = 16'h0000; m_valid = 1'b0; m_pc2_chk = 1'b0;
        end else begin
            m_instr = word; m_pc2 = m_pc + 16'd2; m_valid = 1'b1; m_pc2_chk = 1'b1;
            if (word[15:12] == 4'hF) m_hlt_in_ifid = 1'b1;
            else if (pw) m_pc = m_pc + 16'd2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.pc_wen = 1'b1; bus.if_id_wen = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 16'h1234;
        m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000; m_valid = 1'b0; m_pc2_chk = 1'b1;
        m_hlt_in_ifid = 1'b0; m_halted = 1'b0; m_stall = 0; m_flush = 0;
        @(posedge clk); #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input logic pw, input logic iw, input logic bt, input logic [15:0] tgt);
        rst = 1'b0;
        bus.pc_wen = pw; bus.if_id_wen = iw; bus.branch_taken = bt; bus.branch_target = tgt;
        model_edge(pw, iw, bt, tgt);
        @(posedge clk); #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        logic        pw, iw, bt;
        logic [15:0] tgt, w;

        bus.pc_wen = 1'b0; bus.if_id_wen = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = {8'h10, 8'(i)};

        // T1: reset then straight-line fetch
        do_reset();
        chk("rst_pc", 32'(bus.imem_addr), 32'h0);
        chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
        step(1, 1, 0, 16'h0);
        chk("t1_valid", 32'(bus.if_id_valid), 32'h1);
        chk("t1_pc2", 32'(bus.if_id_pc_plus2), 32'h2);
        step(1, 1, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        chk("t1_pc", 32'(bus.imem_addr), 32'h6);
        chk("t1_instr", 32'(bus.if_id_instr), 32'h1002);
        step(1, 1, 0, 16'h0);

        // T2: full stall at pc 8
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        chk("t2_pc_hold", 32'(bus.imem_addr), 32'h8);
        chk("t2_pc2_hold", 32'(bus.if_id_pc_plus2), 32'h8);

        // T3: taken redirect, then redirect under stall is ignored
        step(1, 1, 0, 16'h0);
        step(1, 1, 1, 16'h0040);
        chk("t3_pc", 32'(bus.imem_addr), 32'h40);
        chk("t3_valid", 32'(bus.if_id_valid), 32'h0);
        step(0, 0, 1, 16'h0080);
        chk("t3_stall_pc", 32'(bus.imem_addr), 32'h40);

        // T4: HLT at 0x0010
        mem[8] = 16'hF000;
        step(1, 1, 1, 16'h0010);
        step(1, 1, 0, 16'h0);
        chk("t4_pc_frozen", 32'(bus.imem_addr), 32'h10);
        chk("t4_not_yet", 32'(bus.fetch_halted), 32'h0);
        step(1, 1, 0, 16'h0);
        chk("t4_halted", 32'(bus.fetch_halted), 32'h1);
        mem[8] = 16'h2222;
        step(1, 1, 1, 16'h0080);
        step(1, 0, 0, 16'h0);
        chk("t4_halt_pc", 32'(bus.imem_addr), 32'h10);
        do_reset();
        chk("t4_rst_pc", 32'(bus.imem_addr), 32'h0);

        // T5: HLT in the wrong-path slot is squashed
        mem[16] = 16'hF123;
        step(1, 1, 1, 16'h0020);
        step(1, 1, 1, 16'h0030);
        chk("t5_pc", 32'(bus.imem_addr), 32'h30);
        step(1, 1, 0, 16'h0);
        chk("t5_running", 32'(bus.imem_addr), 32'h32);
        chk("t5_no_halt", 32'(bus.fetch_halted), 32'h0);

        // T6: wrap at 0xFFFE
        step(1, 1, 1, 16'hFFFE);
        step(1, 1, 0, 16'h0);
        chk("t6_pc2_wrap", 32'(bus.if_id_pc_plus2), 32'h0);
        chk("t6_pc_wrap", 32'(bus.imem_addr), 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom());
            if (w[15:12] == 4'hF && $urandom_range(0, 3) != 0) w[15:12] = 4'hE;
            mem[i] = w;
        end
        for (int n = 0; n < 600; n++) begin
            if ((m_halted && $urandom_range(0, 2) == 0) || $urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                pw  = ($urandom_range(0, 3) != 0);
                iw  = ($urandom_range(0, 3) != 0);
                bt  = ($urandom_range(0, 5) == 0);
                tgt = 16'($urandom()) & 16'hFFFE;
                step(pw, iw, bt, tgt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
